bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 127 ++++++++++++
 tb/tb_bcd_scan_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: scans four BCD stopwatch digits onto a multiplexed 7-segment display as "SS.th".
// Optional leading-zero blanking of the ten-seconds digit is enabled by defining BCD_SCAN_LZ_BLANK_EN.

module bcd_scan_display #(
  parameter int CLK_DIV        = 65000,
  parameter int BLANK_CYCLES   = 1300,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] hundredths_counter,
  input  logic [3:0] tenths_counter,
  input  logic [3:0] seconds_counter,
  input  logic [3:0] ten_seconds_counter,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int            PW          = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST_COUNT  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_COUNT = PW'(BLANK_CYCLES);
  localparam logic          SEG_INV     = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_INV      = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF     = {7{SEG_INV}};
  localparam logic [3:0]    AN_OFF      = {4{AN_INV}};

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; illegal BCD shows a dash
  function automatic logic [6:0] glyph(input logic [3:0] value);
    case (value)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic          enable_q;
  logic [3:0]    shadow    [4];
  logic [3:0]    digit_in  [4];
  logic [3:0]    view      [4];
  logic          slot_end;
  logic          first_load;
  logic          frame_load;
  logic          show_digit;
  logic [3:0]    cur_digit;
  logic [3:0]    an_onehot;

  assign digit_in[0] = hundredths_counter;
  assign digit_in[1] = tenths_counter;
  assign digit_in[2] = seconds_counter;
  assign digit_in[3] = ten_seconds_counter;

  assign slot_end   = (prescaler == LAST_COUNT);
  assign first_load = enable && !enable_q;
  assign frame_load = first_load || (enable && slot_end && (digit_idx == 2'd3));

  // On the snapshot cycle after enable rises, decode the fresh inputs so slot 0 never shows stale data
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      view[i] = first_load ? digit_in[i] : shadow[i];
    end
  end

  assign cur_digit = view[digit_idx];

  always_comb begin
    show_digit = (prescaler >= BLANK_COUNT);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if ((digit_idx == 2'd3) && (view[3] == 4'd0)) begin
      show_digit = 1'b0;
    end
`endif
    an_onehot = show_digit ? (4'b0001 << digit_idx) : 4'b0000;
  end

  // Outputs are registered from the pre-edge scan state, so pins trail the prescaler by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      enable_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
      seg <= SEG_OFF;
      dp  <= SEG_INV;
      an  <= AN_OFF;
    end else begin
      enable_q <= enable;
      if (frame_load) begin
        for (int i = 0; i < 4; i++) begin
          shadow[i] <= digit_in[i];
        end
      end
      if (enable) begin
        if (slot_end) begin
          prescaler <= '0;
          digit_idx <= digit_idx + 2'd1;
        end else begin
          prescaler <= prescaler + PW'(1);
        end
        seg <= glyph(cur_digit) ^ SEG_OFF;
        dp  <= (digit_idx == 2'd2) ^ SEG_INV;
        an  <= an_onehot ^ AN_OFF;
      end else begin
        prescaler <= '0;
        digit_idx <= '0;
        seg       <= SEG_OFF;
        dp        <= SEG_INV;
        an        <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench for bcd_scan_display with CLK_DIV=8, BLANK_CYCLES=2, active-low pins.
// Expected per-cycle pin values are queued when stimulus is driven and popped on every falling edge.

module tb_bcd_scan_display;

  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;

  // Active-low glyphs {g,f,e,d,c,b,a}; entries 10-15 are the dash
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] hundredths_counter;
  logic [3:0] tenths_counter;
  logic [3:0] seconds_counter;
  logic [3:0] ten_seconds_counter;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  bcd_scan_display #(
    .CLK_DIV       (CLK_DIV),
    .BLANK_CYCLES  (BLANK_CYCLES),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .hundredths_counter (hundredths_counter),
    .tenths_counter     (tenths_counter),
    .seconds_counter    (seconds_counter),
    .ten_seconds_counter(ten_seconds_counter),
    .seg                (seg),
    .dp                 (dp),
    .an                 (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after a falling edge so they settle well before the next rising edge
  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] s, input logic [3:0] ts);
    @(negedge clk);
    #1;
    reset_n             = rst_v;
    enable              = en_v;
    hundredths_counter  = h;
    tenths_counter      = t;
    seconds_counter     = s;
    ten_seconds_counter = ts;
  endtask

  task automatic pushFrame(input logic [3:0] h, input logic [3:0] t, input logic [3:0] s, input logic [3:0] ts);
    logic [3:0] d [4];
    logic [3:0] sel;
    exp_t       e;
    d[0] = h; d[1] = t; d[2] = s; d[3] = ts;
    for (int slot = 0; slot < 4; slot++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        sel   = 4'b0001 << slot;
        e.an  = (c < BLANK_CYCLES) ? 4'hF : ~sel;
`ifdef BCD_SCAN_LZ_BLANK_EN
        if (slot == 3 && ts == 4'd0) e.an = 4'hF;
`endif
        e.seg = GLYPH[d[slot]];
        e.dp  = (slot == 2) ? 1'b0 : 1'b1;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic pushOff(input int n);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int left;
    left = budget;
    while (sb_q.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (sb_q.size() != 0) checkOutput("drain_timeout", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput($sformatf("an@%0d", pops), an, e.an);
      checkOutput($sformatf("seg@%0d", pops), seg, e.seg);
      checkOutput($sformatf("dp@%0d", pops), dp, e.dp);
      pops++;
    end
  end

  initial begin
    reset_n             = 1'b0;
    enable              = 1'b0;
    hundredths_counter  = 4'd0;
    tenths_counter      = 4'd0;
    seconds_counter     = 4'd0;
    ten_seconds_counter = 4'd0;
    waitCycles(3);
    checkOutput("rst_an", an, 4'hF);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_dp", dp, 1'b1);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 4'd3, 4'd4, 4'd5, 4'd1);
    pushFrame(4'd3, 4'd4, 4'd5, 4'd1);

    // Mid-slot-1 change: current frame keeps old digits, next frame shows 9s
    waitCycles(9);
    applyStimulus(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    pushFrame(4'd9, 4'd9, 4'd9, 4'd9);

    waitCycles(30);
    applyStimulus(1'b1, 1'b1, 4'hC, 4'd9, 4'd9, 4'd9);
    pushFrame(4'hC, 4'd9, 4'd9, 4'd9);

    // Drop enable two cycles into slot 2 of the dash frame
    waitCycles(41);
    applyStimulus(1'b1, 1'b0, 4'hC, 4'd9, 4'd9, 4'd9);
    sb_q.delete();
    pushOff(3);

    waitCycles(2);
    applyStimulus(1'b1, 1'b1, 4'd7, 4'd8, 4'd0, 4'd2);
    pushFrame(4'd7, 4'd8, 4'd0, 4'd2);

    // Asynchronous reset in the active part of slot 1
    waitCycles(12);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_an", an, 4'hD);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("async_rst_an", an, 4'hF);
    checkOutput("async_rst_seg", seg, 7'h7F);
    checkOutput("async_rst_dp", dp, 1'b1);

    waitCycles(2);
    applyStimulus(1'b1, 1'b1, 4'd6, 4'd2, 4'd8, 4'd0);
    pushFrame(4'd6, 4'd2, 4'd8, 4'd0);
    pushFrame(4'd6, 4'd2, 4'd8, 4'd0);

    waitDrain(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
